// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg : shared state codes and region decode for the memory bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam logic [1:0] IO_REGION = 2'b11;

    // IO space is the top quarter above the RAM index: addr[ram_aw:ram_aw-1] == 2'b11
    function automatic logic is_io(input logic [63:0] addr, input int unsigned ram_aw);
        logic [1:0] region;
        region = 2'(addr >> (ram_aw - 1));
        return region == IO_REGION;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : request vector + search pointer -> one-hot grant and index
// MEMBUS_FIXED_PRIO_EN selects lowest-index-wins and removes the pointer. Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifndef MEMBUS_FIXED_PRIO_EN
    input  logic [IDX_WIDTH-1:0]   ptr,
`endif
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_WIDTH-1:0]   idx
);

    logic found;
    int   k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
`ifdef MEMBUS_FIXED_PRIO_EN
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_WIDTH'(i);
            end
        end
`else
        // Rotate the search so it begins at ptr and wraps past the last master
        for (int i = 0; i < NUM_MASTERS; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_WIDTH'(k);
            end
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : byte-wide multi-master arbiter and RAM/IO decoder
// Option macro MEMBUS_FIXED_PRIO_EN: fixed priority instead of round-robin. Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_WAIT        = 1
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            pause_in,
    input  logic [NUM_MASTERS-1:0]          m_req_in,
    input  logic [NUM_MASTERS-1:0]          m_wr_in,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_in,
    input  logic [NUM_MASTERS*8-1:0]        m_dout_in,
    output logic [NUM_MASTERS-1:0]          m_gnt_out,
    output logic [NUM_MASTERS-1:0]          m_done_out,
    output logic [7:0]                      m_din_out,
    output logic [ADDR_WIDTH-1:0]           mem_a_out,
    output logic                            mem_wr_out,
    output logic [7:0]                      mem_dout_out,
    output logic                            ram_en_out,
    output logic                            io_en_out,
    input  logic [7:0]                      mem_din_in
);

    localparam int IW = $clog2(NUM_MASTERS);

    state_t                  r_state;
    logic [3:0]              r_wait_cnt;
    logic [NUM_MASTERS-1:0]  r_gnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_wr;
    logic [7:0]              r_data;
    logic                    r_is_io;

    logic [NUM_MASTERS-1:0]  w_gnt;
    logic [IW-1:0]           w_idx;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_wr;
    logic [7:0]              w_data;
    logic                    w_access;
    logic                    w_start;

`ifdef MEMBUS_FIXED_PRIO_EN
    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IW)
    ) u_arb (
        .req (m_req_in),
        .gnt (w_gnt),
        .idx (w_idx)
    );
`else
    logic [IW-1:0] r_rr_ptr;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IW)
    ) u_arb (
        .req (m_req_in),
        .ptr (r_rr_ptr),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rr_ptr <= '0;
        end else if (w_start) begin
            r_rr_ptr <= (w_idx == IW'(NUM_MASTERS - 1)) ? '0 : w_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        w_addr = '0;
        w_wr   = 1'b0;
        w_data = 8'h00;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_idx == IW'(i)) begin
                w_addr = m_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wr   = m_wr_in[i];
                w_data = m_dout_in[i*8 +: 8];
            end
        end
    end

    assign w_start = (r_state == ST_IDLE) && (|m_req_in) && !pause_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_gnt      <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_data     <= 8'h00;
            r_is_io    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_gnt   <= w_gnt;
                        r_addr  <= w_addr;
                        r_wr    <= w_wr;
                        r_data  <= w_data;
                        r_is_io <= is_io(64'(w_addr), RAM_ADDR_WIDTH);
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_is_io && (IO_WAIT > 0)) begin
                        r_wait_cnt <= 4'(IO_WAIT - 1);
                        r_state    <= ST_WAIT;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) r_state <= ST_DONE;
                    else                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Enables and the write strobe exist only in ACCESS, so IO side effects happen once
    assign w_access     = (r_state == ST_ACCESS);
    assign ram_en_out   = w_access & ~r_is_io;
    assign io_en_out    = w_access & r_is_io;
    assign mem_wr_out   = w_access & r_wr;
    assign mem_a_out    = r_addr;
    assign mem_dout_out = r_data;
    assign m_gnt_out    = r_gnt;
    assign m_done_out   = (r_state == ST_DONE) ? r_gnt : '0;
    assign m_din_out    = (r_state == ST_DONE) ? mem_din_in : 8'h00;

endmodule

`default_nettype wire
